// File: rtl/id_imm_stage.sv
// Decode-stage front end: classifies the opcode, builds the immediate and queues
// decoded instructions in a 2-entry skid buffer with a registered in_ready.

module imm_generator (
  input  logic [31:7] inst,
  input  logic [2:0]  imm_sel,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (imm_sel)
      3'd0: imm = {{20{inst[31]}}, inst[31:20]};
      3'd1: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd2: imm = {inst[31:12], 12'b0};
      3'd3: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'd4: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      default: imm = '0;
    endcase
  end

endmodule

module id_imm_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [31:0]     imm;
    logic [2:0]      imm_sel;
    logic            illegal;
  } entry_t;

  state_t      state;
  entry_t      head;
  entry_t      skid;
  entry_t      dec;
  logic        in_ready_q;
  logic        out_valid_q;

  logic [2:0]  dec_sel;
  logic        dec_has_imm;
  logic        dec_illegal;
  logic [31:0] gen_imm;
  logic        accept;
  logic        pop;

  always_comb begin
    dec_sel     = 3'd0;
    dec_has_imm = 1'b1;
    dec_illegal = 1'b0;
    unique case (in_inst[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: dec_sel = 3'd0;
      OPC_BRANCH:                    dec_sel = 3'd1;
      OPC_LUI, OPC_AUIPC:            dec_sel = 3'd2;
      OPC_JAL:                       dec_sel = 3'd3;
      OPC_STORE:                     dec_sel = 3'd4;
      OPC_OP:                        dec_has_imm = 1'b0;
      default: begin
        dec_has_imm = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  imm_generator u_imm_generator (
    .inst    (in_inst[31:7]),
    .imm_sel (dec_sel),
    .imm     (gen_imm)
  );

  always_comb begin
    dec.inst    = in_inst;
    dec.pc      = in_pc;
    dec.imm     = dec_has_imm ? gen_imm : '0;
    dec.imm_sel = dec_sel;
    dec.illegal = dec_illegal;
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // in_ready/out_valid are kept as their own flops so neither depends on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      head        <= '0;
      skid        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            head        <= dec;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid       <= dec;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (accept && pop) begin
            head <= dec;
          end else if (pop) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head       <= skid;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_inst    = head.inst;
  assign out_pc      = head.pc;
  assign out_imm     = head.imm;
  assign out_imm_sel = head.imm_sel;
  assign out_illegal = head.illegal;

endmodule
